prog_loader: RTL and testbench

- Boot-time program loader and reset sequencer for the pipelined core.
- Receives a byte stream from a host-side byte source, assembles 32-bit big-endian words and writes them into instruction memory through its write port.
- Verifies a checksum, then releases the core's reset. Holds the core in reset during any reload or error.

---
 rtl/prog_loader_pkg.sv | 16 +
 rtl/prog_loader_word_assembler.sv | 33 +++
 rtl/prog_loader.sv | 133 +++++++++++++
 tb/tb_prog_loader.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
// State encoding, word geometry and checksum width.
package prog_loader_pkg;

   typedef enum logic [2:0] {
      ST_LEN  = 3'd0,
      ST_DATA = 3'd1,
      ST_SUM  = 3'd2,
      ST_RUN  = 3'd3,
      ST_ERR  = 3'd4
   } state_t;

   localparam int BYTES_PER_WORD = 4;
   localparam int SUM_W          = 32;

endpackage

// File: rtl/prog_loader_word_assembler.sv
// Big-endian byte-to-word assembler shared by the length, data and checksum fields.
// The completed word is presented combinationally in the cycle of its last byte.
module prog_loader_word_assembler
   import prog_loader_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             i_clear,
   input  logic             i_valid,
   input  logic [7:0]       i_data,
   output logic [SUM_W-1:0] o_word,
   output logic             o_word_done
);

   localparam int IW = $clog2(BYTES_PER_WORD);

   logic [SUM_W-9:0] r_shift;
   logic [IW-1:0]    r_idx;

   assign o_word      = {r_shift, i_data};
   assign o_word_done = i_valid && (r_idx == IW'(BYTES_PER_WORD - 1));

   always_ff @(posedge clk) begin
      if (rst || i_clear) begin
         r_shift <= '0;
         r_idx   <= '0;
      end else if (i_valid) begin
         r_shift <= o_word[SUM_W-9:0];
         r_idx   <= r_idx + IW'(1);
      end
   end

endmodule

// File: rtl/prog_loader.sv
// Program loader: streams a length/data/checksum packet into imem,
// then releases the core reset once the checksum matches.
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int ADDR_WIDTH     = 12,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rx_valid,
   input  logic [7:0]            rx_data,
   input  logic                  reload,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_wdata,
   output logic                  mem_we,
   output logic                  cpu_rst,
   output logic                  done,
   output logic                  err,
   output logic [ADDR_WIDTH:0]   loaded_words
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int LW = ADDR_WIDTH + 1;
   localparam logic [SUM_W-1:0] MAX_N = SUM_W'(2 ** ADDR_WIDTH);

   state_t r_state, w_next;

   logic [SUM_W-1:0]      r_sum;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [LW-1:0]         r_n;
   logic [LW-1:0]         r_cnt;
   logic [TW-1:0]         r_tmo;
   logic                  r_started;
   logic                  r_we;
   logic [31:0]           r_wdata;

   logic             w_loading;
   logic             w_rx;
   logic             w_done;
   logic             w_last;
   logic             w_tmo_hit;
   logic [SUM_W-1:0] w_word;

   assign w_loading = (r_state == ST_LEN) || (r_state == ST_DATA) ||
                      (r_state == ST_SUM);
   // A reload in the same cycle drops the byte.
   assign w_rx      = rx_valid && !reload && w_loading;
   assign w_last    = (r_cnt + LW'(1)) == r_n;
   assign w_tmo_hit = w_loading && r_started && !w_rx &&
                      (r_tmo == TW'(TIMEOUT_CYCLES - 1));

   prog_loader_word_assembler u_word_assembler (
      .clk         (clk),
      .rst         (rst),
      .i_clear     (reload),
      .i_valid     (w_rx),
      .i_data      (rx_data),
      .o_word      (w_word),
      .o_word_done (w_done)
   );

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_LEN;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      if (reload) begin
         w_next = ST_LEN;
      end else if (w_tmo_hit) begin
         w_next = ST_ERR;
      end else if (w_done) begin
         unique case (r_state)
            ST_LEN: begin
               if (w_word == '0)        w_next = ST_SUM;
               else if (w_word > MAX_N) w_next = ST_ERR;
               else                     w_next = ST_DATA;
            end
            ST_DATA: if (w_last) w_next = ST_SUM;
            ST_SUM:  w_next = (w_word == r_sum) ? ST_RUN : ST_ERR;
            default: w_next = r_state;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wdata <= '0;
         r_n     <= '0;
      end else if (r_state == ST_DATA && w_done && !reload) begin
         r_wdata <= w_word;
      end else if (r_state == ST_LEN && w_done && !reload) begin
         r_n <= w_word[LW-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst || reload) begin
         r_sum     <= '0;
         r_addr    <= '0;
         r_cnt     <= '0;
         r_tmo     <= '0;
         r_started <= 1'b0;
         r_we      <= 1'b0;
      end else begin
         r_we <= 1'b0;
         if (r_we) r_addr <= r_addr + ADDR_WIDTH'(1);
         if (w_rx) begin
            r_started <= 1'b1;
            r_tmo     <= '0;
         end else if (r_started && w_loading &&
                      r_tmo != TW'(TIMEOUT_CYCLES)) begin
            r_tmo <= r_tmo + TW'(1);
         end
         if (r_state == ST_DATA && w_done) begin
            r_we  <= 1'b1;
            r_sum <= r_sum + w_word;
            r_cnt <= r_cnt + LW'(1);
         end
      end
   end

   assign mem_addr     = r_addr;
   assign mem_wdata    = r_wdata;
   assign mem_we       = r_we;
   assign cpu_rst      = (r_state != ST_RUN);
   assign done         = (r_state == ST_RUN);
   assign err          = (r_state == ST_ERR);
   assign loaded_words = r_cnt;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed packets plus randomized
// packets checked against a packet-level reference model.
module tb_prog_loader;

   localparam int AW = 12;

   logic          clk = 1'b0;
   logic          rst;
   logic          rx_valid;
   logic [7:0]    rx_data;
   logic          reload;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic          mem_we;
   logic          cpu_rst;
   logic          done;
   logic          err;
   logic [AW:0]   loaded_words;

   int n_chk  = 0;
   int n_pass = 0;

   logic [AW-1:0] wa[$];
   logic [31:0]   wd[$];

   prog_loader #(
      .ADDR_WIDTH     (AW),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .rx_valid     (rx_valid),
      .rx_data      (rx_data),
      .reload       (reload),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_we       (mem_we),
      .cpu_rst      (cpu_rst),
      .done         (done),
      .err          (err),
      .loaded_words (loaded_words)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (mem_we) begin
         wa.push_back(mem_addr);
         wd.push_back(mem_wdata);
      end
   end

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input int max_gap);
      logic [31:0] v;
      v = w;
      for (int i = 0; i < 4; i++) begin
         send_byte(v[31:24]);
         v = v << 8;
         if (max_gap > 0 && i < 3) idle($urandom_range(0, max_gap));
      end
   endtask

   task automatic do_reload();
      reload = 1'b1;
      @(posedge clk);
      #1;
      reload = 1'b0;
      wa.delete();
      wd.delete();
   endtask

   task automatic check_status(input string tag, input bit exp_run,
                               input bit exp_err);
      check({tag, ".done"}, done, exp_run);
      check({tag, ".err"}, err, exp_err);
      check({tag, ".cpu_rst"}, cpu_rst, !exp_run);
   endtask

   task automatic random_packet(input int k);
      int          n;
      bit          big;
      bit          bad;
      logic [31:0] hdr;
      logic [31:0] sum;
      logic [31:0] cs;
      logic [31:0] words[$];
      string       t;
      t   = $sformatf("rnd%0d", k);
      n   = $urandom_range(0, 6);
      big = ($urandom_range(0, 9) == 0);
      hdr = big ? 32'd4097 + 32'($urandom_range(0, 100000)) : 32'(n);
      do_reload();
      send_word(hdr, 3);
      if (big) begin
         check_status({t, ".big"}, 1'b0, 1'b1);
         check({t, ".big.nwr"}, 64'(wa.size()), 64'd0);
         return;
      end
      sum = 32'd0;
      for (int i = 0; i < n; i++) begin
         words.push_back($urandom);
         sum = sum + words[i];
         idle($urandom_range(0, 3));
         send_word(words[i], 3);
      end
      bad = ($urandom_range(0, 3) == 0);
      cs  = bad ? (sum ^ (32'd1 << $urandom_range(0, 31))) : sum;
      idle($urandom_range(0, 3));
      send_word(cs, 3);
      check({t, ".nwr"}, 64'(wa.size()), 64'(n));
      for (int i = 0; i < n && i < wa.size(); i++) begin
         check({t, ".addr"}, 64'(wa[i]), 64'(i));
         check({t, ".data"}, 64'(wd[i]), 64'(words[i]));
      end
      check_status(t, !bad, bad);
      check({t, ".loaded"}, 64'(loaded_words), 64'(n));
      for (int i = 0; i < 4; i++) send_byte(8'($urandom));
      idle(2);
      check({t, ".ign.nwr"}, 64'(wa.size()), 64'(n));
      check_status({t, ".ign"}, !bad, bad);
   endtask

   initial begin
      rst      = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      reload   = 1'b0;
      idle(3);
      check("rst.cpu_rst", cpu_rst, 1'b1);
      check("rst.done", done, 1'b0);
      check("rst.err", err, 1'b0);
      check("rst.we", mem_we, 1'b0);
      check("rst.addr", 64'(mem_addr), 64'd0);
      check("rst.wdata", 64'(mem_wdata), 64'd0);
      check("rst.loaded", 64'(loaded_words), 64'd0);
      rst = 1'b0;
      idle(1);

      // Good two-word packet with exact latency checks
      send_word(32'd2, 0);
      send_word(32'hDEADBEEF, 0);
      check("a.we_lat", mem_we, 1'b1);
      check("a.addr0", 64'(mem_addr), 64'd0);
      check("a.data0", 64'(mem_wdata), 64'hDEADBEEF);
      idle(1);
      check("a.we_low", mem_we, 1'b0);
      check("a.addr_inc", 64'(mem_addr), 64'd1);
      send_word(32'h00000001, 0);
      send_word(32'hDEADBEF0, 0);
      check_status("a", 1'b1, 1'b0);
      check("a.nwr", 64'(wa.size()), 64'd2);
      if (wa.size() == 2) begin
         check("a.wa1", 64'(wa[1]), 64'd1);
         check("a.wd1", 64'(wd[1]), 64'h00000001);
      end
      check("a.loaded", 64'(loaded_words), 64'd2);

      // Bad checksum
      do_reload();
      check_status("rl", 1'b0, 1'b0);
      send_word(32'd2, 0);
      send_word(32'hDEADBEEF, 0);
      send_word(32'h00000001, 0);
      send_word(32'hDEADBEEF, 0);
      check_status("b", 1'b0, 1'b1);

      // Empty program
      do_reload();
      send_word(32'd0, 0);
      send_word(32'd0, 0);
      check_status("z", 1'b1, 1'b0);
      check("z.nwr", 64'(wa.size()), 64'd0);
      check("z.loaded", 64'(loaded_words), 64'd0);

      // Oversize header
      do_reload();
      send_word(32'h00001001, 0);
      check_status("big", 1'b0, 1'b1);
      idle(2);
      check("big.nwr", 64'(wa.size()), 64'd0);

      // Inter-byte timeout
      do_reload();
      send_byte(8'h00);
      send_byte(8'h00);
      idle(15);
      check("to.early", err, 1'b0);
      idle(1);
      check("to.err", err, 1'b1);

      // Idle before the first byte is legal
      do_reload();
      idle(1000);
      check_status("wait", 1'b0, 1'b0);
      send_word(32'd1, 0);
      send_word(32'h12345678, 0);
      send_word(32'h12345678, 0);
      check_status("wait.load", 1'b1, 1'b0);

      // Reload racing a byte in RUN
      reload   = 1'b1;
      rx_valid = 1'b1;
      rx_data  = 8'hAA;
      @(posedge clk);
      #1;
      reload   = 1'b0;
      rx_valid = 1'b0;
      wa.delete();
      wd.delete();
      check_status("race", 1'b0, 1'b0);
      check("race.loaded", 64'(loaded_words), 64'd0);
      check("race.addr", 64'(mem_addr), 64'd0);
      send_word(32'd1, 0);
      send_word(32'hCAFEF00D, 0);
      send_word(32'hCAFEF00D, 0);
      check_status("race.load", 1'b1, 1'b0);
      check("race.nwr", 64'(wa.size()), 64'd1);
      if (wa.size() == 1) begin
         check("race.wa", 64'(wa[0]), 64'd0);
         check("race.wd", 64'(wd[0]), 64'hCAFEF00D);
      end

      // Reset mid-load, then a clean load
      do_reload();
      send_word(32'd1, 0);
      send_byte(8'h11);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      wa.delete();
      wd.delete();
      check_status("mid", 1'b0, 1'b0);
      check("mid.loaded", 64'(loaded_words), 64'd0);
      check("mid.addr", 64'(mem_addr), 64'd0);
      send_word(32'd1, 0);
      send_word(32'h0BADF00D, 0);
      send_word(32'h0BADF00D, 0);
      check_status("mid.load", 1'b1, 1'b0);
      check("mid.nwr", 64'(wa.size()), 64'd1);

      for (int k = 0; k < 30; k++) random_packet(k);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
